// File: rtl/ddr_pkg.sv
// Shared constants for the DDR SDRAM data paths: bus geometry and the
// legal CAS / burst ranges checked when the read and write paths elaborate.
package ddr_pkg;
    localparam int DQ_WIDTH   = 16;
    localparam int WORD_WIDTH = 32;
    localparam int LANES      = 2;

    localparam int CAS_MIN   = 2;
    localparam int CAS_MAX   = 8;
    localparam int BURST_MIN = 1;
    localparam int BURST_MAX = 4;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction
endpackage

// File: rtl/ddr_rdfifo.sv
// Synchronous show-ahead FIFO: the head word sits on data_o whenever valid_o
// is high, and data_o reads as zero while the FIFO is empty.
module ddr_rdfifo
    import ddr_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH,
    parameter int DEPTH = 8
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     ready_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      count_q, count_d;
    logic             pop;

    assign valid_o = (count_q != '0);
    assign pop     = valid_o && ready_i;
    assign data_o  = valid_o ? mem_q[rd_q] : '0;
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (push_i && !pop) count_d = count_q + (AW+1)'(1);
        if (pop && !push_i) count_d = count_q - (AW+1)'(1);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + AW'(1);
            if (pop)    rd_q <= rd_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Storage carries no reset; stale entries are never visible past count_q.
    always_ff @(posedge clock_i) begin
        if (push_i) mem_q[wr_q] <= data_i;
    end

    a_no_overflow: assert property (@(posedge clock_i) disable iff (reset_i)
        !(push_i && !pop && count_q == (AW+1)'(DEPTH)));
endmodule

// File: rtl/ddr_read_path.sv
// DDR read data path: times IOB capture strobes from READ commands, buffers
// the returned words and hands them to the consumer with valid/ready.
module ddr_read_path
    import ddr_pkg::*;
#(
    parameter int CAS_LATENCY = 3,
    parameter int BURST_WORDS = 2,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  rd_cmd_i,
    output logic                  rd_ready_o,
    output logic [LANES-1:0]      capture_o,
    input  logic [WORD_WIDTH-1:0] data_i,
    output logic [WORD_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  busy_o,
    output logic                  cmd_err_o
);
    localparam int SR_LEN = CAS_LATENCY + BURST_WORDS + 1;
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;

    if (CAS_LATENCY < CAS_MIN || CAS_LATENCY > CAS_MAX) begin : g_bad_cl
        $error("ddr_read_path: CAS_LATENCY out of range");
    end
    if (BURST_WORDS < BURST_MIN || BURST_WORDS > BURST_MAX) begin : g_bad_bw
        $error("ddr_read_path: BURST_WORDS out of range");
    end
    if (!is_pow2(FIFO_DEPTH) || FIFO_DEPTH < 2 * BURST_WORDS) begin : g_bad_depth
        $error("ddr_read_path: FIFO_DEPTH must be a power of two >= 2*BURST_WORDS");
    end

    // sr_q[k] is set k+1 cycles after an accepted command.
    logic [SR_LEN-1:0] sr_q, sr_d;
    logic [CW-1:0]     wif_q, wif_d;
    logic [CW-1:0]     fifo_count;
    logic              err_q, err_d;
    logic              accept, push, too_soon, strobe;
    logic [CW:0]       credit_used;

    always_comb begin
        too_soon = 1'b0;
        for (int k = 0; k < BURST_WORDS - 1; k++) too_soon = too_soon | sr_q[k];
    end

    assign credit_used = {1'b0, fifo_count} + {1'b0, wif_q} + (CW+1)'(BURST_WORDS);
    assign rd_ready_o  = (credit_used <= (CW+1)'(FIFO_DEPTH));
    assign accept      = rd_cmd_i && rd_ready_o && !too_soon;

    // Strobe window, then the same window one cycle later for the IOB register.
    assign strobe    = |sr_q[CAS_LATENCY-1 +: BURST_WORDS];
    assign push      = |sr_q[CAS_LATENCY +: BURST_WORDS];
    assign capture_o = {LANES{strobe}};
    assign busy_o    = (wif_q != '0) || (|sr_q);
    assign cmd_err_o = err_q;

    always_comb begin
        sr_d  = {sr_q[SR_LEN-2:0], accept};
        err_d = err_q | (rd_cmd_i && !accept);
        wif_d = wif_q;
        if (accept) wif_d = wif_d + CW'(BURST_WORDS);
        if (push)   wif_d = wif_d - CW'(1);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            sr_q  <= '0;
            wif_q <= '0;
            err_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            wif_q <= wif_d;
            err_q <= err_d;
        end
    end

    ddr_rdfifo #(
        .WIDTH (WORD_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .push_i  (push),
        .data_i  (data_i),
        .ready_i (ready_i),
        .data_o  (data_o),
        .valid_o (valid_o),
        .count_o (fifo_count)
    );
endmodule

// File: tb/tb_ddr_read_path.sv
// Randomised bench for ddr_read_path against a cycle-scheduled behavioural
// model: a word queue, an in-flight credit count and per-cycle event tables.
module tb_ddr_read_path;
    localparam int CL   = 3;
    localparam int BW   = 2;
    localparam int D    = 8;
    localparam int L    = CL + BW + 1;
    localparam int MAXC = 8192;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        rd_cmd_i = 1'b0;
    logic        rd_ready_o;
    logic [1:0]  capture_o;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic        busy_o;
    logic        cmd_err_o;

    ddr_read_path #(.CAS_LATENCY(CL), .BURST_WORDS(BW), .FIFO_DEPTH(D)) dut (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .rd_cmd_i   (rd_cmd_i),
        .rd_ready_o (rd_ready_o),
        .capture_o  (capture_o),
        .data_i     (data_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .busy_o     (busy_o),
        .cmd_err_o  (cmd_err_o)
    );

    always #5 clock_i = ~clock_i;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int pops    = 0;

    // Reference model state
    logic [31:0] mq[$];
    int          m_wif  = 0;
    int          m_last = -1000;
    bit          m_err  = 0;
    bit          m_live = 0;
    bit          cap_at [MAXC];
    bit          smp_at [MAXC];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit m_ready();
        return (D - mq.size() - m_wif) >= BW;
    endfunction

    task automatic cycle(input bit cmd, input bit rdy, input bit rst, input logic [31:0] din);
        bit pop;
        @(negedge clock_i);
        if (m_live) begin
            chk("capture", {30'd0, capture_o}, cap_at[cyc] ? 32'd3 : 32'd0);
            chk("valid", {31'd0, valid_o}, {31'd0, mq.size() != 0});
            chk("data", data_o, (mq.size() != 0) ? mq[0] : 32'd0);
            chk("rd_ready", {31'd0, rd_ready_o}, {31'd0, m_ready()});
            chk("cmd_err", {31'd0, cmd_err_o}, {31'd0, m_err});
            if (m_wif > 0)             chk("busy", {31'd0, busy_o}, 32'd1);
            else if (cyc - m_last > L) chk("busy", {31'd0, busy_o}, 32'd0);
        end
        rd_cmd_i = cmd;
        ready_i  = rdy;
        reset_i  = rst;
        data_i   = din;
        if (valid_o === 1'b1 && rdy && !rst) pops++;

        if (rst) begin
            mq.delete();
            m_wif  = 0;
            m_last = -1000;
            m_err  = 0;
            for (int k = cyc + 1; k < cyc + 20 && k < MAXC; k++) begin
                cap_at[k] = 0;
                smp_at[k] = 0;
            end
            m_live = 1;
        end else begin
            pop = (mq.size() != 0) && rdy;
            if (cmd) begin
                if (m_ready() && (cyc - m_last >= BW)) begin
                    m_wif  += BW;
                    m_last = cyc;
                    for (int k = 0; k < BW; k++) begin
                        cap_at[cyc + CL + k]     = 1;
                        smp_at[cyc + CL + 1 + k] = 1;
                    end
                end else begin
                    m_err = 1;
                end
            end
            if (pop) void'(mq.pop_front());
            if (smp_at[cyc]) begin
                mq.push_back(din);
                m_wif--;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        cycle(0, 0, 1, $urandom);
        cycle(0, 0, 1, $urandom);
        cycle(0, 0, 0, $urandom);
    endtask

    initial begin
        do_reset();

        // Single burst with fixed data words
        pops = 0;
        for (int r = 0; r < 22; r++)
            cycle(r == 10, 1, 0, (r == 14) ? 32'hFFAA_0033 : (r == 15) ? 32'h1234_5678 : $urandom);
        chk("t1_words", pops, 2);

        // Back-to-back commands at burst spacing
        pops = 0;
        for (int r = 0; r < 30; r++)
            cycle(r == 10 || r == 12 || r == 14 || r == 16, 1, 0, $urandom);
        chk("t2_words", pops, 8);
        chk("t2_err", {31'd0, cmd_err_o}, 32'd0);

        // Fill credit with consumer stalled; 5th command must be rejected
        do_reset();
        pops = 0;
        for (int r = 0; r < 60; r++)
            cycle(r < 10 && (r % 2 == 0), r >= 25, 0, $urandom);
        chk("t3_words", pops, 8);
        chk("t3_err", {31'd0, cmd_err_o}, 32'd1);
        chk("t3_ready", {31'd0, rd_ready_o}, 32'd1);

        // Second command one cycle too early
        do_reset();
        pops = 0;
        for (int r = 0; r < 25; r++)
            cycle(r == 10 || r == 11, 1, 0, $urandom);
        chk("t4_words", pops, 2);
        chk("t4_err", {31'd0, cmd_err_o}, 32'd1);

        // Reset in the middle of a burst
        do_reset();
        pops = 0;
        for (int r = 0; r < 30; r++)
            cycle(r == 10, 1, r == 14, $urandom);
        chk("t5_words", pops, 0);

        // Random traffic with occasional resets
        for (int r = 0; r < 2000; r++)
            cycle(($urandom % 100) < 35, ($urandom % 100) < 60, ($urandom % 200) == 0, $urandom);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
